// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of one shared, registered Gray-to-binary stage.
// Winner's Gray word is captured in IDLE, converted in CONV and offered in HOLD.
module gray_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    gray_in,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [W-1:0]         bin_out,
  output logic [ID_W-1:0]      bin_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   win_q, win_d;
  logic [W-1:0]      gray_q, gray_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              bin_valid_q, bin_valid_d;
  logic [W-1:0]      bin_out_q, bin_out_d;
  logic [ID_W-1:0]   bin_id_q, bin_id_d;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [NREQ-1:0]   pick_oh;
  logic [W-1:0]      pick_gray;
  int                idx;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Scan starting at rr_ptr, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_oh   = '0;
    pick_gray = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        pick         = ID_W'(idx);
        pick_oh[idx] = 1'b1;
        pick_gray    = gray_in[idx*W +: W];
      end
    end
  end

  // Output handshake: a result transfers on any edge where bin_valid && bin_ready;
  // until then bin_out/bin_id stay frozen and no new request is captured.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    gray_d      = gray_q;
    grant_d     = '0;
    bin_valid_d = bin_valid_q;
    bin_out_d   = bin_out_q;
    bin_id_d    = bin_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          gray_d  = pick_gray;
          grant_d = pick_oh;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_out_d   = gray2bin(gray_q);
        bin_id_d    = win_q;
        bin_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bin_valid_q && bin_ready) begin
          bin_valid_d = 1'b0;
          rr_ptr_d    = (win_q == ID_W'(NREQ - 1)) ? '0 : win_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      gray_q      <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      bin_valid_q <= 1'b0;
      bin_out_q   <= '0;
      bin_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      gray_q      <= gray_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      bin_valid_q <= bin_valid_d;
      bin_out_q   <= bin_out_d;
      bin_id_q    <= bin_id_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign bin_valid = bin_valid_q;
  assign bin_out   = bin_out_q;
  assign bin_id    = bin_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus random
// transactions checked against a transaction-level round-robin/XOR-prefix model.
module tb_gray_conv_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   gray_in;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                bin_valid;
  logic                bin_ready;
  logic [W-1:0]        bin_out;
  logic [ID_W-1:0]     bin_id;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [ID_W+W-1:0] exp_q[$];

  gray_conv_arbiter #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gray_in   (gray_in),
    .grant     (grant),
    .busy      (busy),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_out   (bin_out),
    .bin_id    (bin_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: bit i of the binary word is the parity of Gray bits W-1..i.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE through acceptance; r_after is what the
  // requesters present once the grant has been seen.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] g,
                         input logic [NREQ-1:0] r_after, input int stall);
    int w;
    logic [ID_W+W-1:0] e;
    w = rr_pick(r, model_ptr);
    req = r;
    gray_in = g;
    bin_ready = 1'($urandom_range(0, 1));
    exp_q.push_back({ID_W'(w), ref_bin(g[w*W +: W])});
    tick();
    check("grant", grant, 32'(1) << w);
    check("busy_conv", busy, 1);
    check("valid_conv", bin_valid, 0);
    req = r_after;
    gray_in = (NREQ*W)'($urandom);
    bin_ready = 1'($urandom_range(0, 1));
    tick();
    e = exp_q.pop_front();
    check("grant_drop", grant, 0);
    check("valid_hold", bin_valid, 1);
    check("bin_id", bin_id, e[ID_W+W-1:W]);
    check("bin_out", bin_out, e[W-1:0]);
    for (int s = 0; s < stall; s++) begin
      bin_ready = 1'b0;
      req = (stall > 0 && r_after != r) ? NREQ'($urandom) : r_after;
      gray_in = (NREQ*W)'($urandom);
      tick();
      check("stall_valid", bin_valid, 1);
      check("stall_out", bin_out, e[W-1:0]);
      check("stall_id", bin_id, e[ID_W+W-1:W]);
      check("stall_grant", grant, 0);
      check("stall_busy", busy, 1);
    end
    bin_ready = 1'b1;
    tick();
    check("accept_valid", bin_valid, 0);
    check("accept_busy", busy, 0);
    check("accept_grant", grant, 0);
    bin_ready = 1'b0;
    req = r_after;
    model_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    logic [NREQ*W-1:0] g;
    int w;
    rst_n = 1'b0;
    req = '0;
    gray_in = '0;
    bin_ready = 1'b0;
    #12;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", bin_valid, 0);
    check("rst_out", bin_out, 0);
    check("rst_id", bin_id, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Request withdrawn before any edge, bin_ready high in IDLE: nothing happens.
    req = 4'b0010;
    bin_ready = 1'b1;
    #2 req = '0;
    tick();
    check("nocap_grant", grant, 0);
    check("nocap_busy", busy, 0);
    check("nocap_valid", bin_valid, 0);
    bin_ready = 1'b0;

    // Directed: requester 2 with Gray 1011, then rr_ptr=3 sends 1001 to 3 then 0.
    run_txn(4'b0100, 16'h0B00, 4'b0000, 0);
    run_txn(4'b1001, 16'h5A3C, 4'b1001, 1);
    run_txn(4'b1001, 16'hC3A6, 4'b0000, 0);

    // Every Gray code through requester 0.
    for (int c = 0; c < (1 << W); c++) begin
      run_txn(4'b0001, (NREQ*W)'(c), 4'b0000, 0);
    end

    // Backpressure with toggling inputs.
    run_txn(4'b0110, (NREQ*W)'($urandom), 4'b1111, 5);
    run_txn(4'b1111, (NREQ*W)'($urandom), 4'b0000, 0);

    // Asynchronous reset while holding a result.
    req = 4'b1000;
    g = (NREQ*W)'($urandom);
    gray_in = g;
    w = rr_pick(req, model_ptr);
    tick();
    check("pre_rst_grant", grant, 32'(1) << w);
    req = '0;
    tick();
    check("pre_rst_valid", bin_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bin_valid, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_out", bin_out, 0);
    model_ptr = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // All requesters held high: strict rotation from index 0.
    for (int n = 0; n < 6; n++) begin
      run_txn(4'b1111, (NREQ*W)'($urandom), 4'b1111, 0);
    end
    req = '0;

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      logic [NREQ-1:0] r;
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_txn(r, (NREQ*W)'($urandom), '0, $urandom_range(0, 3));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
